// File: rtl/core_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte-enable
// patterns, the registered request record and the alignment rule.
package core_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_ILL  = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_ACCESS = 3'b010;
    localparam logic [2:0] ST_RESP   = 3'b100;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // Request fields still needed after the memory request has been launched.
    typedef struct packed {
        logic [1:0] addr_lo;
        logic [1:0] size;
        logic       we;
        logic       uns;
    } lsu_req_t;

    // Size 3 is always rejected; halves need an even address, words a 4-byte one.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane steering: store data replication / byte enables on the way
// out, byte/half extraction with sign or zero extension on the way back.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic        st_we,
    input  logic [31:0] st_wdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_uns,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift_s;

    // Store side: replicate the source into every lane, enables pick the real one.
    always_comb begin
        mem_wdata = 32'h0000_0000;
        mem_be    = BE_ALL;
        if (st_we) begin
            case (st_size)
                SIZE_BYTE: begin
                    mem_wdata = {4{st_wdata[7:0]}};
                    mem_be    = BE_B0 << st_addr_lo;
                end
                SIZE_HALF: begin
                    mem_wdata = {2{st_wdata[15:0]}};
                    mem_be    = st_addr_lo[1] ? BE_HI : BE_LO;
                end
                SIZE_WORD: begin
                    mem_wdata = st_wdata;
                    mem_be    = BE_ALL;
                end
                default: begin
                    mem_wdata = 32'h0000_0000;
                    mem_be    = BE_NONE;
                end
            endcase
        end else begin
            mem_wdata = 32'h0000_0000;
            mem_be    = BE_ALL;
        end
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shift_s = mem_rdata >> {ld_addr_lo, 3'b000};
        case (ld_size)
            SIZE_BYTE: ld_data = ld_uns ? {24'h00_0000, ld_shift_s[7:0]}
                                        : {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            SIZE_HALF: ld_data = ld_uns ? {16'h0000, ld_shift_s[15:0]}
                                        : {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            SIZE_WORD: ld_data = mem_rdata;
            default:   ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP with alignment
// checking, lane steering and an ACK timeout; all outputs come from registers.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        D_MEM_REQ,
    output logic        D_MEM_WE,
    output logic [31:0] D_MEM_ADDR,
    output logic [31:0] D_MEM_WDATA,
    output logic [3:0]  D_MEM_BE,
    input  logic        D_MEM_ACK,
    input  logic [31:0] D_MEM_RDATA
);

    // Counter value in the last ACCESS cycle before the access is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    lsu_req_t    req_r;
    logic        ready_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_be_r;

    logic        misaligned_s;
    logic        accept_s;
    logic        start_s;
    logic        done_s;
    logic        err_nxt_s;
    logic [31:0] rdata_nxt_s;
    logic [31:0] st_wdata_s;
    logic [3:0]  st_be_s;
    logic [31:0] ld_data_s;

    assign misaligned_s = lsu_misaligned(REQ_SIZE, REQ_ADDR[1:0]);

    core_lsu_align u_align (
        .st_addr_lo (REQ_ADDR[1:0]),
        .st_size    (REQ_SIZE),
        .st_we      (REQ_WE),
        .st_wdata   (REQ_WDATA),
        .mem_wdata  (st_wdata_s),
        .mem_be     (st_be_s),
        .ld_addr_lo (req_r.addr_lo),
        .ld_size    (req_r.size),
        .ld_uns     (req_r.uns),
        .mem_rdata  (D_MEM_RDATA),
        .ld_data    (ld_data_s)
    );

    // Next-state, timeout and completion decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        start_s     = 1'b0;
        done_s      = 1'b0;
        err_nxt_s   = 1'b0;
        rdata_nxt_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    accept_s = 1'b1;
                    if (misaligned_s) begin
                        state_nxt_s = ST_RESP;
                        done_s      = 1'b1;
                        err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACCESS;
                        start_s     = 1'b1;
                        cnt_nxt_s   = 16'h0000;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ACK in the final counted cycle still completes normally.
                if (D_MEM_ACK) begin
                    state_nxt_s = ST_RESP;
                    done_s      = 1'b1;
                    rdata_nxt_s = req_r.we ? 32'h0000_0000 : ld_data_s;
                end else if (cnt_r == TO_LAST) begin
                    state_nxt_s = ST_RESP;
                    done_s      = 1'b1;
                    err_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'h0000;
            end
        endcase
    end

    // Control state, request record and response registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'h0000;
            req_r       <= '0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ready_r     <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= done_s;
            rsp_err_r   <= err_nxt_s;
            rsp_rdata_r <= rdata_nxt_s;
            if (accept_s) begin
                req_r.addr_lo <= REQ_ADDR[1:0];
                req_r.size    <= REQ_SIZE;
                req_r.we      <= REQ_WE;
                req_r.uns     <= REQ_UNSIGNED;
            end
        end
    end

    // Memory-side outputs: loaded at launch, held through ACCESS, cleared on completion.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= BE_NONE;
        end else if (start_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= REQ_WE;
            mem_addr_r  <= {REQ_ADDR[31:2], 2'b00};
            mem_wdata_r <= st_wdata_s;
            mem_be_r    <= st_be_s;
        end else if (done_s) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= BE_NONE;
        end
    end

    assign REQ_READY   = ready_r;
    assign RSP_VALID   = rsp_valid_r;
    assign RSP_ERR     = rsp_err_r;
    assign RSP_RDATA   = rsp_rdata_r;
    assign D_MEM_REQ   = mem_req_r;
    assign D_MEM_WE    = mem_we_r;
    assign D_MEM_ADDR  = mem_addr_r;
    assign D_MEM_WDATA = mem_wdata_r;
    assign D_MEM_BE    = mem_be_r;

endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of ACCESS cycles without D_MEM_ACK before the access is abandoned (range 1..65535).
REQ-002 RST_N  in  1  synchronous reset, active-low.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 REQ_VALID  in  1  core requests a data access.
REQ-005 REQ_READY  out  1  LSU accepts a request this cycle.
REQ-006 REQ_ADDR  in  32  byte address (ALU result).
REQ-007 REQ_WDATA  in  32  store source (rs2), data in bits [7:0]/[15:0]/[31:0].
REQ-008 REQ_WE  in  1  1 = store, 0 = load.
REQ-009 REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 REQ_UNSIGNED  in  1  load zero-extends (LBU/LHU) instead of sign-extending.
REQ-011 RSP_VALID  out  1  one-cycle completion strobe.
REQ-012 RSP_RDATA  out  32  extended load data; 0 for stores and errors.
REQ-013 RSP_ERR  out  1  misaligned, illegal-size or timed-out access; valid with RSP_VALID.
REQ-014 D_MEM_REQ / D_MEM_WE  out  1 / 1  memory request, write enable.
REQ-015 D_MEM_ADDR  out  32  word-aligned address (REQ_ADDR with [1:0] = 0).
REQ-016 D_MEM_WDATA / D_MEM_BE  out  32 / 4  lane-replicated store data, byte enables.
REQ-017 D_MEM_ACK / D_MEM_RDATA  in  1 / 32  memory completion, read word (valid with ACK).

Function
REQ-018 States SHALL be IDLE, ACCESS, RESP, one-hot encoded; REQ_READY = 1 only in IDLE.
REQ-019 IDLE: on REQ_VALID, the LSU SHALL register addr/wdata/we/size/unsigned; go to RESP with error if misaligned, otherwise go to ACCESS.
REQ-020 Misaligned SHALL mean: half with addr[0] = 1, word with addr[1:0] != 0, or SIZE = 3; no memory request is issued for these.
REQ-021 ACCESS: D_MEM_REQ SHALL be held at 1 with stable address/data/BE/WE until the cycle D_MEM_ACK = 1; next state is RESP.
REQ-022 Store lanes: byte -> WDATA = {4{b}}, BE = 4'b0001 << addr[1:0]; half -> {2{h}}, BE = addr[1] ? 1100 : 0011; word -> BE = 1111; loads drive BE = 1111 and WDATA = 0.
REQ-023 Load extract: the selected byte/half (shifted by 8*addr[1:0]) SHALL be sign- or zero-extended to 32 bits per REQ_UNSIGNED and captured on ACK.
REQ-024 Timeout counter: cleared on entry to ACCESS, incremented each ACCESS cycle without ACK; on reaching TIMEOUT_CYCLES the LSU SHALL go to RESP with RSP_ERR = 1 and drop D_MEM_REQ.
REQ-025 ACK in the same cycle the counter reaches TIMEOUT_CYCLES: ACK wins, RSP_ERR = 0.
REQ-026 RESP: RSP_VALID = 1 for exactly one cycle, then IDLE; new requests are not accepted in RESP.
REQ-027 Latency: with ACK in the first ACCESS cycle, RSP_VALID SHALL assert 2 cycles after the accepting edge; the error path SHALL take 1 cycle.
REQ-028 D_MEM_ACK outside ACCESS SHALL be ignored.

Reset
REQ-029 While RST_N = 0, state SHALL be IDLE, the counter 0, and outputs REQ_READY = 1, RSP_VALID = 0, RSP_ERR = 0, RSP_RDATA = 0, D_MEM_REQ = 0, D_MEM_WE = 0, D_MEM_BE = 0, D_MEM_ADDR = 0, D_MEM_WDATA = 0.
REQ-030 Reset asserted during ACCESS SHALL abandon the access and deassert D_MEM_REQ at the next edge, with no RSP_VALID.

Structure
REQ-031 Package core_lsu_pkg SHALL hold the SIZE encodings, state encodings and the BE constants.
REQ-032 A combinational sub-module core_lsu_align SHALL perform store lane replication/BE generation and load extraction/extension.

Verification
REQ-033 Store byte: addr 0x1003, wdata 0x000000AB -> D_MEM_ADDR 0x1000, BE 1000, WDATA 0xABABABAB; RSP_VALID with ERR 0, RDATA 0.
REQ-034 Load byte signed/unsigned: addr 0x2002, memory returns 0x12F45678 -> LB gives 0xFFFFFFF4, LBU gives 0x000000F4.
REQ-035 Load half: addr 0x2002, memory returns 0x80015678 -> LH gives 0xFFFF8001, LHU gives 0x00008001; addr 0x2001 -> ERR 1 after 1 cycle, D_MEM_REQ never asserted.
REQ-036 Timeout: TIMEOUT_CYCLES = 4, no ACK -> RSP_ERR 1 after 4 ACCESS cycles; a repeat with ACK in the 4th cycle -> ERR 0 with the data returned.
REQ-037 Wait states: ACK after 3 cycles with D_MEM_* stable throughout; REQ_VALID held during ACCESS/RESP is not accepted until IDLE.
REQ-038 Reset mid-ACCESS -> D_MEM_REQ 0 next cycle, no RSP_VALID, REQ_READY 1.
